// File: rtl/game_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : game_round_ctrl
// Purpose  : Round sequencer for the cannon game. Starts a game, requests a
//            fresh target, gates aiming, fires each shot into the trajectory
//            calculator, waits for the verdict (with timeout) and keeps the
//            score and the number of shots remaining.
// Ports    : clk, reset (async, active-high), ena (global enable)
//            start_new_game (level, rising edge starts/restarts a game)
//            shoot_req (sampled in AIM only)
//            result_valid / hit (verdict strobe from trajectory_calc)
//            shoot_go, new_target (one-cycle pulses)
//            aim_enable, state[2:0], shots_left[3:0], score[3:0]
//            game_over, win, calc_timeout (sticky per game)
// Revision : 1.0 - initial release
// ============================================================================
module game_round_ctrl #(
  parameter int SHOTS_PER_GAME = 8,   // 1..15
  parameter int WIN_HITS       = 5,   // 1..15
  parameter int CALC_TIMEOUT   = 64   // 2..255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ena,
  input  logic       start_new_game,
  input  logic       shoot_req,
  input  logic       result_valid,
  input  logic       hit,
  output logic       shoot_go,
  output logic       new_target,
  output logic       aim_enable,
  output logic [2:0] state,
  output logic [3:0] shots_left,
  output logic [3:0] score,
  output logic       game_over,
  output logic       win,
  output logic       calc_timeout
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_NEW_TGT  = 3'd1,
    S_AIM      = 3'd2,
    S_FIRE     = 3'd3,
    S_WAIT_RES = 3'd4,
    S_SCORE    = 3'd5,
    S_OVER     = 3'd6
  } state_t;

  localparam logic [3:0] C_SHOTS_INIT  = 4'(SHOTS_PER_GAME);
  localparam logic [3:0] C_WIN_HITS    = 4'(WIN_HITS);
  localparam logic [7:0] C_TIMER_LAST  = 8'(CALC_TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [3:0] score_q, score_d;
  logic [3:0] shots_left_q, shots_left_d;
  logic       win_q, win_d;
  logic       calc_timeout_q, calc_timeout_d;
  logic [7:0] timer_q, timer_d;
  logic       start_q, start_d;
  logic       hit_q, hit_d;

  logic       start_edge;
  logic [3:0] score_next;

  assign start_edge = start_new_game & ~start_q;
  // Score as it would be after crediting the latched verdict in SCORE.
  assign score_next = score_q + {3'b000, hit_q};

  always_comb begin
    state_d        = state_q;
    score_d        = score_q;
    shots_left_d   = shots_left_q;
    win_d          = win_q;
    calc_timeout_d = calc_timeout_q;
    timer_d        = timer_q;
    start_d        = start_q;
    hit_d          = hit_q;

    if (ena) begin
      start_d = start_new_game;
      if (start_edge) begin
        // Restart overrides everything, including an in-flight shot.
        score_d        = 4'd0;
        shots_left_d   = C_SHOTS_INIT;
        win_d          = 1'b0;
        calc_timeout_d = 1'b0;
        hit_d          = 1'b0;
        state_d        = S_NEW_TGT;
      end else begin
        case (state_q)
          S_IDLE: state_d = S_IDLE;
          S_NEW_TGT: state_d = S_AIM;
          S_AIM: begin
            if (shoot_req) state_d = S_FIRE;
          end
          S_FIRE: begin
            shots_left_d = shots_left_q - 4'd1;
            timer_d      = 8'd0;
            state_d      = S_WAIT_RES;
          end
          S_WAIT_RES: begin
            timer_d = timer_q + 8'd1;
            if (result_valid) begin
              // A verdict in the timeout cycle still counts.
              hit_d   = hit;
              state_d = S_SCORE;
            end else if (timer_q == C_TIMER_LAST) begin
              hit_d          = 1'b0;
              calc_timeout_d = 1'b1;
              state_d        = S_SCORE;
            end
          end
          S_SCORE: begin
            score_d = score_next;
            if (score_next == C_WIN_HITS) begin
              win_d   = 1'b1;
              state_d = S_OVER;
            end else if (shots_left_q == 4'd0) begin
              win_d   = 1'b0;
              state_d = S_OVER;
            end else if (hit_q) begin
              state_d = S_NEW_TGT;
            end else begin
              state_d = S_AIM;
            end
          end
          S_OVER: state_d = S_OVER;
          default: state_d = S_IDLE;  // unused encoding 7
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      score_q        <= 4'd0;
      shots_left_q   <= C_SHOTS_INIT;
      win_q          <= 1'b0;
      calc_timeout_q <= 1'b0;
      timer_q        <= 8'd0;
      start_q        <= 1'b0;
      hit_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      score_q        <= score_d;
      shots_left_q   <= shots_left_d;
      win_q          <= win_d;
      calc_timeout_q <= calc_timeout_d;
      timer_q        <= timer_d;
      start_q        <= start_d;
      hit_q          <= hit_d;
    end
  end

  // Pulses come straight from the registered state, gated by ena so a
  // frozen FSM never stretches them.
  assign shoot_go     = ena & (state_q == S_FIRE);
  assign new_target   = ena & (state_q == S_NEW_TGT);
  assign aim_enable   = (state_q == S_AIM);
  assign game_over    = (state_q == S_OVER);
  assign state        = state_q;
  assign shots_left   = shots_left_q;
  assign score        = score_q;
  assign win          = win_q;
  assign calc_timeout = calc_timeout_q;

endmodule
`default_nettype wire

// File: doc/game_round_ctrl.md
Name: game_round_ctrl

Overview:
Round sequencer for the cannon game. It starts a game, requests a fresh target and gates aiming. It fires each shot into the trajectory calculator, waits for the verdict, then keeps score and shots remaining. It sits between the controls decoder (start/shoot), target_gen (new_target), pos_aim (aim_enable) and trajectory_calc (shoot_go, result_valid/hit), and replaces ad-hoc direct wiring of shoot and start_new_game.

Parameters:
SHOTS_PER_GAME, 8, shots per game; legal range 1..15
WIN_HITS, 5, hits needed to win; legal range 1..15
CALC_TIMEOUT, 64, max cycles to wait for result_valid after a shot; legal range 2..255

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
ena  in  1  design enable; when low all state holds and pulse outputs are 0
start_new_game  in  1  level input; rising edge starts or restarts a game
shoot_req  in  1  shoot request from controls, sampled only in AIM
result_valid  in  1  one-cycle verdict strobe from trajectory_calc
hit  in  1  verdict, qualified by result_valid
shoot_go  out  1  one-cycle fire pulse to trajectory_calc
new_target  out  1  one-cycle pulse to target_gen
aim_enable  out  1  high while the cannon may move or aim
state  out  3  current FSM state encoding (debug/display)
shots_left  out  4  shots remaining
score  out  4  hits this game
game_over  out  1  high in OVER
win  out  1  valid while game_over; 1 = WIN_HITS reached
calc_timeout  out  1  sticky; set when a shot timed out; cleared at game start

Behaviour:
- Reset (async, active-high) state values:
  - state=IDLE, score=0, shots_left=SHOTS_PER_GAME
  - win=0, calc_timeout=0, timer=0
  - start edge register = 0
  - all pulse outputs 0
- States and encoding: IDLE=0, NEW_TGT=1, AIM=2, FIRE=3, WAIT_RES=4, SCORE=5, OVER=6. Value 7 is unused and recovers to IDLE on the next enabled edge.
- Start edge detection:
  - start_edge = start_new_game & ~start_q.
  - start_q updates only when ena=1.
  - start_edge has top priority in every state. It clears score, calc_timeout and win, loads shots_left=SHOTS_PER_GAME, and moves to NEW_TGT.
  - A restart mid-shot (FIRE/WAIT_RES) abandons that shot; a later result_valid is ignored.
- Per-state behaviour (all transitions on enabled clock edges):
  - IDLE: aim_enable=0. Waits for start_edge.
  - NEW_TGT: new_target=1 for exactly this cycle, then AIM.
  - AIM: aim_enable=1. shoot_req=1 moves to FIRE. shoot_req in any other state is ignored, not queued.
  - FIRE: shoot_go=1 for exactly this cycle. shots_left decrements by 1. timer clears. Then WAIT_RES. aim_enable=0 from FIRE through SCORE.
  - WAIT_RES: timer increments each cycle.
    - result_valid=1: latch hit, go to SCORE.
    - Else timer==CALC_TIMEOUT-1: treat as miss, set calc_timeout, go to SCORE.
    - result_valid and timeout in the same cycle: result wins, calc_timeout stays unchanged.
  - SCORE (one cycle): if the latched hit is set, score increments.
    - new score==WIN_HITS: go to OVER, win=1.
    - else shots_left==0: go to OVER, win=0.
    - else if hit: go to NEW_TGT.
    - else: go to AIM (same target).
  - OVER: game_over=1. score, shots_left and win hold. Waits for start_edge.
- Timing:
  - shoot_req sampled at edge N gives shoot_go high in cycle N+1.
  - result_valid at edge M puts SCORE in cycle M+1; updated score is visible from cycle M+2.
- result_valid outside WAIT_RES is ignored.
- Pulses are decoded from the registered state and gated with ena, so each is exactly one cycle wide.
- ena=0 freezes the FSM, counters and timer, and forces new_target=0 and shoot_go=0. Level outputs hold their values.
- Widths: score and shots_left are 4-bit and never wrap; parameter limits guarantee this. timer is 8-bit.

Test Plan:
- Reset then start_new_game rising edge:
  - new_target pulses 1 cycle and state goes 1 then 2.
  - shots_left=8, score=0, aim_enable=1.
- In AIM, pulse shoot_req:
  - shoot_go is high exactly 1 cycle, one cycle later; shots_left=7.
  - result_valid=1, hit=1 three cycles later gives score=1, then new_target pulses and state returns to AIM.
- Miss path:
  - result_valid=1, hit=0 gives score unchanged, no new_target pulse, return to AIM.
  - Repeating until shots_left=0 ends in state=6, game_over=1, win=0.
- Five consecutive hits with WIN_HITS=5: game_over=1, win=1, shots_left=3, score=5.
- Timeout: no result_valid for 64 cycles after shoot_go gives calc_timeout=1, score unchanged, state returns to AIM. A result_valid arriving afterwards is ignored.
- Restart and enable handling:
  - start_new_game edge during WAIT_RES gives state=NEW_TGT, score=0, shots_left=8, calc_timeout=0.
  - Holding ena=0 for 10 cycles in AIM with shoot_req=1 gives no shoot_go and no state change.
  - Asserting reset mid-FIRE gives state=0 immediately (async).
